// File: rtl/aq_djpeg_feeder.sv
// aq_djpeg_feeder: packs a ready/valid byte stream big-endian into 32-bit words behind a FWFT FIFO.
// Define AQ_DJPEG_FEEDER_SOI_EN to discard input until an FF D8 start-of-image marker is seen.
module aq_djpeg_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Flush,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteInValid,
    input  logic                  ByteInLast,
    output logic                  ByteInReady,
    output logic [31:0]           DataIn,
    output logic                  DataInEnable,
    input  logic                  DataInRead,
    output logic [DEPTH_LOG2:0]   WordCount,
    output logic                  PackBusy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [1:0]            byteIdx_r;
    logic [23:0]           hold_r;
    logic [31:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_r;
    logic [DEPTH_LOG2-1:0] rdPtr_r;
    logic [DEPTH_LOG2:0]   count_r;

    logic        accept_s;
    logic        packEn_s;
    logic        soiHit_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] packed_s;

    // Ready is forced low while reset is held so nothing is offered into a clearing design.
    assign ByteInReady  = rst && (count_r != FULL_COUNT) && !Flush;
    assign accept_s     = ByteInValid && ByteInReady;
    assign DataInEnable = (count_r != {(DEPTH_LOG2+1){1'b0}});
    assign DataIn       = DataInEnable ? mem_r[rdPtr_r] : 32'h0000_0000;
    assign WordCount    = count_r;
    assign PackBusy     = (byteIdx_r != 2'd0);
    assign push_s       = packEn_s && ((byteIdx_r == 2'd3) || ByteInLast);
    assign pop_s        = DataInRead && DataInEnable;

    // Merge the incoming byte into its lane; unfilled lanes of hold_r are always zero.
    always_comb begin
        packed_s = 32'h0000_0000;
        case (byteIdx_r)
            2'd0:    packed_s = {ByteIn, 24'h00_0000};
            2'd1:    packed_s = {hold_r[23:16], ByteIn, 16'h0000};
            2'd2:    packed_s = {hold_r[23:8], ByteIn, 8'h00};
            2'd3:    packed_s = {hold_r, ByteIn};
            default: packed_s = 32'h0000_0000;
        endcase
    end

`ifdef AQ_DJPEG_FEEDER_SOI_EN
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HUNT_FF = 2'd1,
        PASS    = 2'd2
    } huntState_t;

    huntState_t hunt_r;

    // Decide whether an accepted byte is packed, completes the SOI marker, or is dropped.
    always_comb begin
        packEn_s = 1'b0;
        soiHit_s = 1'b0;
        if (accept_s) begin
            case (hunt_r)
                PASS:    packEn_s = 1'b1;
                HUNT_FF: soiHit_s = (ByteIn == 8'hD8) && !ByteInLast;
                default: packEn_s = 1'b0;
            endcase
        end else begin
            packEn_s = 1'b0;
        end
    end

    // SOI hunt state machine; a Last byte always rearms the hunt for the next file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hunt_r <= HUNT;
        end else if (Flush) begin
            hunt_r <= HUNT;
        end else if (accept_s) begin
            if (ByteInLast) begin
                hunt_r <= HUNT;
            end else begin
                case (hunt_r)
                    HUNT:    hunt_r <= (ByteIn == 8'hFF) ? HUNT_FF : HUNT;
                    HUNT_FF: hunt_r <= (ByteIn == 8'hD8) ? PASS :
                                       (ByteIn == 8'hFF) ? HUNT_FF : HUNT;
                    PASS:    hunt_r <= PASS;
                    default: hunt_r <= HUNT;
                endcase
            end
        end
    end
`else
    assign packEn_s = accept_s;
    assign soiHit_s = 1'b0;
`endif

    // Packer: byte index and holding register for the partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteIdx_r <= 2'd0;
            hold_r    <= 24'h00_0000;
        end else if (Flush) begin
            byteIdx_r <= 2'd0;
            hold_r    <= 24'h00_0000;
        end else if (soiHit_s) begin
            byteIdx_r <= 2'd2;
            hold_r    <= {8'hFF, 8'hD8, 8'h00};
        end else if (packEn_s) begin
            if (push_s) begin
                byteIdx_r <= 2'd0;
                hold_r    <= 24'h00_0000;
            end else begin
                byteIdx_r <= byteIdx_r + 2'd1;
                hold_r    <= packed_s[31:8];
            end
        end
    end

    // FIFO storage; contents need no reset because DataIn is masked while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wrPtr_r] <= packed_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_r <= {DEPTH_LOG2{1'b0}};
            rdPtr_r <= {DEPTH_LOG2{1'b0}};
            count_r <= {(DEPTH_LOG2+1){1'b0}};
        end else if (Flush) begin
            wrPtr_r <= {DEPTH_LOG2{1'b0}};
            rdPtr_r <= {DEPTH_LOG2{1'b0}};
            count_r <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_aq_djpeg_feeder.sv
// Randomized, cycle-accurate check of aq_djpeg_feeder against a queue-based reference model.
module tb_aq_djpeg_feeder;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Flush = 1'b0;
    logic [7:0]    ByteIn = 8'h00;
    logic          ByteInValid = 1'b0;
    logic          ByteInLast = 1'b0;
    logic          ByteInReady;
    logic [31:0]   DataIn;
    logic          DataInEnable;
    logic          DataInRead = 1'b0;
    logic [DL:0]   WordCount;
    logic          PackBusy;

    always #5 clk = ~clk;

    aq_djpeg_feeder #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .Flush(Flush),
        .ByteIn(ByteIn), .ByteInValid(ByteInValid), .ByteInLast(ByteInLast),
        .ByteInReady(ByteInReady), .DataIn(DataIn), .DataInEnable(DataInEnable),
        .DataInRead(DataInRead), .WordCount(WordCount), .PackBusy(PackBusy)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] wordQ[$];
    logic [7:0]  partQ[$];
    int          hunt = 0;   // 0 hunting, 1 saw FF, 2 passing
    bit          soiEn = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one accepted byte.
    task automatic modelByte(input logic [7:0] b, input logic last);
        logic [31:0] w;
        if (soiEn && hunt != 2) begin
            if (last) hunt = 0;
            else if (hunt == 1 && b == 8'hD8) begin
                partQ.delete();
                partQ.push_back(8'hFF);
                partQ.push_back(8'hD8);
                hunt = 2;
            end
            else if (b == 8'hFF) hunt = 1;
            else hunt = 0;
            return;
        end
        if (last) hunt = 0;
        partQ.push_back(b);
        if (partQ.size() == 4 || last) begin
            w = 32'h0;
            for (int i = 0; i < 4; i++)
                w = {w[23:0], (i < partQ.size()) ? partQ[i] : 8'h00};
            wordQ.push_back(w);
            partQ.delete();
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic v, input logic [7:0] b, input logic l,
                        input logic rd, input logic fl);
        logic expReady, acc, pop;
        ByteInValid = v; ByteIn = b; ByteInLast = l; DataInRead = rd; Flush = fl;
        #1;
        expReady = rst && (wordQ.size() < DEPTH) && !fl;
        checkValue("ready", 32'(ByteInReady), 32'(expReady));
        checkValue("enable", 32'(DataInEnable), 32'(wordQ.size() != 0));
        checkValue("data", DataIn, (wordQ.size() != 0) ? wordQ[0] : 32'h0);
        checkValue("count", 32'(WordCount), 32'(wordQ.size()));
        checkValue("busy", 32'(PackBusy), 32'(partQ.size() != 0));
        acc = v && expReady;
        pop = rd && (wordQ.size() != 0);
        @(posedge clk);
        if (!rst || fl) begin
            wordQ.delete(); partQ.delete(); hunt = 0;
        end else begin
            if (pop) void'(wordQ.pop_front());
            if (acc) modelByte(b, l);
        end
        @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic l);
        step(1'b1, b, l, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] maxCnt;
        int r;
        logic [7:0] rb;
`ifdef AQ_DJPEG_FEEDER_SOI_EN
        soiEn = 1'b1;
`endif
        #1 rst = 1'b0;
        @(negedge clk);
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Basic packing, padding on Last, one-cycle latency.
        sendByte(8'hFF, 1'b0); sendByte(8'hD8, 1'b0);
        sendByte(8'hFF, 1'b0); sendByte(8'hE0, 1'b0);
        checkValue("t1_word0", DataIn, 32'hFFD8FFE0);
        sendByte(8'h00, 1'b0); sendByte(8'h10, 1'b1);
        checkValue("t1_busy", 32'(PackBusy), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkValue("t1_word1", DataIn, 32'h00100000);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkValue("t1_empty", 32'(DataInEnable), 32'd0);

        // Fill to full with reads held low, then one pop.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        sendByte(8'hFF, 1'b0); sendByte(8'hD8, 1'b0);
        for (int i = 0; i < 14; i++) sendByte(8'($urandom), 1'b0);
        checkValue("full_ready", 32'(ByteInReady), 32'd0);
        checkValue("full_count", 32'(WordCount), 32'd4);
        for (int i = 0; i < 4; i++) sendByte(8'($urandom), 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        checkValue("refill_ready", 32'(ByteInReady), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Flush with 3 words buffered and 2 bytes packed.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        sendByte(8'hFF, 1'b0); sendByte(8'hD8, 1'b0);
        for (int i = 0; i < 12; i++) sendByte(8'($urandom), 1'b0);
        checkValue("pre_flush_count", 32'(WordCount), 32'd3);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        checkValue("flush_count", 32'(WordCount), 32'd0);
        checkValue("flush_enable", 32'(DataInEnable), 32'd0);
        checkValue("flush_data", DataIn, 32'h0);
        checkValue("flush_busy", 32'(PackBusy), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef AQ_DJPEG_FEEDER_SOI_EN
        // Leading junk discarded until FF D8.
        sendByte(8'h12, 1'b0); sendByte(8'hFF, 1'b0); sendByte(8'hFF, 1'b0);
        sendByte(8'hD8, 1'b0); sendByte(8'hE0, 1'b0); sendByte(8'h01, 1'b0);
        checkValue("soi_word", DataIn, 32'hFFD8E001);
        checkValue("soi_count", 32'(WordCount), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized traffic with occasional Last and Flush.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            rb = (r == 0) ? 8'hFF : (r == 1) ? 8'hD8 : 8'($urandom);
            step($urandom_range(0, 3) != 0, rb, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
        end

        // Continuous streaming with reads held high across pointer wrap.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hD8, 1'b0, 1'b1, 1'b0);
        maxCnt = 32'd0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
            if (32'(WordCount) > maxCnt) maxCnt = 32'(WordCount);
        end
        checkValue("stream_maxcount", maxCnt, 32'd1);

        // Asynchronous reset mid-word with data buffered.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        sendByte(8'hFF, 1'b0); sendByte(8'hD8, 1'b0);
        for (int i = 0; i < 9; i++) sendByte(8'($urandom), 1'b0);
        checkValue("pre_rst_busy", 32'(PackBusy), 32'd1);
        rst = 1'b0;
        #1;
        checkValue("rst_ready", 32'(ByteInReady), 32'd0);
        checkValue("rst_enable", 32'(DataInEnable), 32'd0);
        checkValue("rst_data", DataIn, 32'h0);
        checkValue("rst_count", 32'(WordCount), 32'd0);
        checkValue("rst_busy", 32'(PackBusy), 32'd0);
        wordQ.delete(); partQ.delete(); hunt = 0;
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sendByte(8'hFF, 1'b0); sendByte(8'hD8, 1'b0);
        sendByte(8'h11, 1'b0); sendByte(8'h22, 1'b0);
        checkValue("post_rst_word", DataIn, 32'hFFD81122);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aq_djpeg_feeder.md
# aq_djpeg_feeder

Byte-to-word feeder for the JPEG decoder input port. It accepts a ready/valid byte stream from a file source such as an SD, UART or DMA reader. It packs the bytes big-endian into 32-bit words, buffers them in a first-word-fall-through FIFO, and presents them on the DataIn / DataInEnable / DataInRead word interface that the decoder's register-data stage consumes.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 words.
- rst  in  1: asynchronous reset, active low.
- clk  in  1: the single clock.
- Flush  in  1: synchronous clear of the packer, the FIFO and the hunt state.
- ByteIn  in  8: input byte.
- ByteInValid  in  1: ByteIn is valid.
- ByteInLast  in  1: qualifies the last byte of the file.
- ByteInReady  out  1: the feeder accepts a byte this cycle.
- DataIn  out  32: head word, first byte in [31:24]; 0 when DataInEnable is low.
- DataInEnable  out  1: the FIFO is non-empty.
- DataInRead  in  1: pop the head word.
- WordCount  out  DEPTH_LOG2+1: words held in the FIFO.
- PackBusy  out  1: the packer holds 1–3 bytes not yet pushed.

## Operation
- A byte is accepted when ByteInValid and ByteInReady are both high. ByteInReady = !FifoFull && !Flush.
- Packer: a 2-bit byte index ByteIdx and a 24-bit holding register.
  - Byte k (k = 0..3) goes to lane [31-8k:24-8k].
  - When the 4th byte is accepted, the packed word is pushed to the FIFO on that edge and ByteIdx returns to 0.
- Last handling: an accepted byte with ByteInLast high pushes the word immediately. Lanes not yet filled are padded with 0x00. ByteIdx is then cleared.
- FIFO: register array with wr_ptr and rd_ptr (DEPTH_LOG2 bits, wrapping) and a count.
  - DataIn = mem[rd_ptr] (combinational, first-word fall-through).
  - A pop occurs when DataInRead && DataInEnable. DataInRead while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged.
  - Because ByteInReady is low when full, a push never overflows.
- Flush: clears the pointers, count, ByteIdx, holding register and hunt state on the next edge. A byte offered during the Flush cycle is not accepted.
- Reset values: ByteInReady 1 after reset release (0 during reset), DataIn 0, DataInEnable 0, WordCount 0, PackBusy 0.

## Timing
- A byte that completes a word at edge N makes DataInEnable high in cycle N+1 if the FIFO was empty. Latency is 1 cycle.
- A pop at edge N presents the next word, or deasserts DataInEnable, in cycle N+1.
- When full with no pop in cycle N: ByteInReady is low in cycle N. A pop at edge N makes ByteInReady high in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 byte per cycle in, 1 word per cycle out.
- Asynchronous reset mid-transfer discards all buffered data and partial words.

## Configuration
- AQ_DJPEG_FEEDER_SOI_EN defined: SOI hunt state machine.
  - States: HUNT, HUNT_FF, PASS.
  - HUNT: accepted bytes are discarded. A 0xFF byte moves to HUNT_FF.
  - HUNT_FF: 0xD8 writes 0xFF and 0xD8 into lanes 0 and 1 in the same cycle, sets ByteIdx=2, and moves to PASS. 0xFF stays in HUNT_FF. Any other byte returns to HUNT.
  - PASS: normal packing. An accepted Last byte returns to HUNT.
  - Flush and reset enter HUNT.
  - A Last byte accepted in HUNT or HUNT_FF is discarded, and the state moves to HUNT.
  - ByteInReady rules are unchanged; bytes are consumed while hunting.
- Undefined: the state machine is absent and every accepted byte is packed, as in PASS.

## Test plan
- Bytes FF D8 FF E0 then 00 10 with Last on 0x10 (macro undefined) -> words 0xFFD8FFE0 then 0x00100000, each 1 cycle after its last byte; PackBusy returns to 0.
- DEPTH_LOG2=2, 20 bytes, DataInRead held low -> ByteInReady drops after the 16th byte and WordCount=4. One pop restores ByteInReady the next cycle; words remain in order.
- Continuous bytes with DataInRead held high -> one word per 4 cycles. Push and pop at the same edge keep WordCount at 1; no loss or duplication across pointer wrap.
- Flush asserted with 2 bytes packed and 3 words buffered -> next cycle WordCount=0, DataInEnable=0, DataIn=0, PackBusy=0.
- Macro defined, bytes 12 FF FF D8 E0 01 -> only word 0xFFD8E001 is produced; leading 12 FF are discarded.
- rst low mid-word (ByteIdx=3, FIFO non-empty) -> all outputs at reset values immediately. After release, a fresh 4-byte stream packs starting at lane 0.
